// File: rtl/mips32_mem_responder.sv
// -----------------------------------------------------------------------------
// mips32_mem_responder
//   Memory-side responder for the MIPS32 load/store path. It accepts one word
//   request (LW read or SW write) over a valid/ready handshake, performs it on
//   an internal word-addressed RAM and returns one response over a second
//   valid/ready handshake. Only one transaction is outstanding at a time. The
//   read latency is fixed and set by a parameter.
//
//   Ports
//     clk1_i        clock; all state updates on the rising edge
//     rst_ni        asynchronous active-low reset
//     req_valid_i   request present
//     req_ready_o   responder can accept a request (high only in IDLE)
//     req_we_i      1 = write (SW), 0 = read (LW)
//     req_addr_i    word address, ADDR_W bits
//     req_wdata_i   write data, DATA_W bits
//     rsp_valid_o   response present
//     rsp_ready_i   initiator accepts the response
//     rsp_rdata_o   read data; 0 for writes and for out-of-range accesses
//     rsp_err_o     address was >= DEPTH
//
//   Timing
//     rsp_valid_o rises RD_LAT clock edges after the accept edge. It is cleared
//     on the edge where rsp_ready_i is sampled high, and req_ready_o returns
//     high on that same edge, so the next accept is one edge later.
// -----------------------------------------------------------------------------
module mips32_mem_responder #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int RD_LAT = 2
) (
   input  logic              clk1_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              rsp_err_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // DEPTH may equal 2**ADDR_W, so the bound needs one extra bit.
   localparam logic [ADDR_W:0] DEPTH_C    = (ADDR_W + 1)'(DEPTH);
   localparam logic [3:0]      LAT_LOAD_C = 4'(RD_LAT - 1);

   state_e              state_q;
   logic [3:0]          cnt_q;
   logic                we_q;
   logic                err_q;
   logic                req_ready_q;
   logic                rsp_valid_q;
   logic                rsp_err_q;
   logic [DATA_W-1:0]   rsp_rdata_q;
   logic [DATA_W-1:0]   rd_word_q;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                accept_s;
   logic                in_range_s;
   logic                mem_wr_s;

   // Unsigned compare over the full address width: no wrap into the RAM.
   assign in_range_s = ({1'b0, req_addr_i} < DEPTH_C);
   assign accept_s   = req_valid_i && req_ready_q;
   assign mem_wr_s   = accept_s && req_we_i && in_range_s;

   assign req_ready_o = req_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;

   // RAM array: write commits and read capture both happen at the accept edge.
   // Not reset, so a committed write survives a later reset. The captured word
   // is masked to zero later for writes and out-of-range accesses.
   always_ff @(posedge clk1_i) begin
      if (mem_wr_s) begin
         mem_q[req_addr_i] <= req_wdata_i;
      end
      if (accept_s && in_range_s) begin
         rd_word_q <= mem_q[req_addr_i];
      end
   end

   // Transaction FSM with registered handshake and response outputs.
   always_ff @(posedge clk1_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         we_q        <= 1'b0;
         err_q       <= 1'b0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= {DATA_W{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid_i) begin
                  we_q        <= req_we_i;
                  err_q       <= !in_range_s;
                  cnt_q       <= LAT_LOAD_C;
                  req_ready_q <= 1'b0;
                  state_q     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // The RESP outputs are registered on the edge that leaves WAIT,
               // which puts rsp_valid exactly RD_LAT edges after the accept
               // edge (RD_LAT==1 spends a single cycle here).
               if (cnt_q == 4'd0) begin
                  state_q     <= ST_RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= err_q;
                  rsp_rdata_q <= (we_q || err_q) ? {DATA_W{1'b0}} : rd_word_q;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_RESP: begin
               // Outputs hold while the initiator back-pressures.
               if (rsp_ready_i) begin
                  state_q     <= ST_IDLE;
                  req_ready_q <= 1'b1;
                  rsp_valid_q <= 1'b0;
                  rsp_err_q   <= 1'b0;
                  rsp_rdata_q <= {DATA_W{1'b0}};
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
               rsp_err_q   <= 1'b0;
               rsp_rdata_q <= {DATA_W{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips32_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mips32_mem_responder
//   Directed self-checking bench for mips32_mem_responder. Three instances:
//     index 0: DEPTH=1000, RD_LAT=2  (write/read, back-pressure, range, reset)
//     index 1: DEPTH=1024, RD_LAT=1  (latency sweep, back-to-back)
//     index 2: DEPTH=1024, RD_LAT=8  (latency sweep, back-to-back)
//   Inputs are driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_mips32_mem_responder;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic [2:0]  req_valid;
   logic [2:0]  req_we;
   logic [2:0]  rsp_ready;
   logic [9:0]  req_addr  [3];
   logic [31:0] req_wdata [3];
   wire  [2:0]  req_ready;
   wire  [2:0]  rsp_valid;
   wire  [2:0]  rsp_err;
   wire  [31:0] rsp_rdata [3];

   int n_tests = 0;
   int n_fail  = 0;
   int lat_tab [3];

   always #5 clk = ~clk;

   mips32_mem_responder #(.ADDR_W(10), .DATA_W(32), .DEPTH(1000), .RD_LAT(2)) u_dut_a (
      .clk1_i(clk), .rst_ni(rst_ni),
      .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
      .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
      .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
      .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0]));

   mips32_mem_responder #(.ADDR_W(10), .DATA_W(32), .DEPTH(1024), .RD_LAT(1)) u_dut_b (
      .clk1_i(clk), .rst_ni(rst_ni),
      .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
      .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
      .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
      .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1]));

   mips32_mem_responder #(.ADDR_W(10), .DATA_W(32), .DEPTH(1024), .RD_LAT(8)) u_dut_c (
      .clk1_i(clk), .rst_ni(rst_ni),
      .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]), .req_we_i(req_we[2]),
      .req_addr_i(req_addr[2]), .req_wdata_i(req_wdata[2]),
      .rsp_valid_o(rsp_valid[2]), .rsp_ready_i(rsp_ready[2]),
      .rsp_rdata_o(rsp_rdata[2]), .rsp_err_o(rsp_err[2]));

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // Present one request for exactly one edge; req_ready must be high first.
   task automatic accept(input int i, input logic we, input logic [9:0] a,
                         input logic [31:0] d, input string tag);
      check_eq({tag, "_rdy"}, 32'(req_ready[i]), 32'd1);
      req_valid[i] = 1'b1;
      req_we[i]    = we;
      req_addr[i]  = a;
      req_wdata[i] = d;
      cycle();
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = 10'd0;
      req_wdata[i] = 32'd0;
   endtask

   // Count edges after the accept edge until rsp_valid; bounded at 20.
   task automatic wait_rsp(input int i, input string tag);
      int lat;
      lat = 0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         cycle();
         if (rsp_valid[i]) lat = k;
      end
      check_eq({tag, "_lat"}, 32'(lat), 32'(lat_tab[i]));
   endtask

   // Full transaction with rsp_ready held high.
   task automatic txn(input int i, input logic we, input logic [9:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rdata, input logic exp_err, input string tag);
      rsp_ready[i] = 1'b1;
      accept(i, we, a, d, tag);
      wait_rsp(i, tag);
      check_eq({tag, "_rdata"}, rsp_rdata[i], exp_rdata);
      check_eq({tag, "_err"}, 32'(rsp_err[i]), 32'(exp_err));
      cycle();
      check_eq({tag, "_vld0"}, 32'(rsp_valid[i]), 32'd0);
      check_eq({tag, "_rdy1"}, 32'(req_ready[i]), 32'd1);
   endtask

   // Back-to-back reads with req_valid and rsp_ready held high. Accept edge,
   // RD_LAT edges to rsp_valid, one handshake edge, then the next accept:
   // accepts land RD_LAT+2 edges apart.
   task automatic stream(input int i, input string tag);
      int acc [$];
      int per;
      per = lat_tab[i] + 2;
      rsp_ready[i] = 1'b1;
      req_valid[i] = 1'b1;
      req_we[i]    = 1'b0;
      req_addr[i]  = 10'd3;
      for (int k = 0; k < 3 * per + 2; k++) begin
         if (req_ready[i]) acc.push_back(k);
         cycle();
      end
      req_valid[i] = 1'b0;
      check_eq({tag, "_nacc"}, 32'(acc.size()), 32'd4);
      for (int j = 1; j < acc.size(); j++) begin
         check_eq({tag, "_gap"}, 32'(acc[j] - acc[j-1]), 32'(per));
      end
      repeat (lat_tab[i]) cycle();
      check_eq({tag, "_drain"}, 32'(req_ready[i]), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      lat_tab[0] = 2;
      lat_tab[1] = 1;
      lat_tab[2] = 8;
      rst_ni    = 1'b0;
      req_valid = 3'b000;
      req_we    = 3'b000;
      rsp_ready = 3'b000;
      for (int i = 0; i < 3; i++) begin
         req_addr[i]  = 10'd0;
         req_wdata[i] = 32'd0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         check_eq("rst_rdy",   32'(req_ready[i]), 32'd1);
         check_eq("rst_vld",   32'(rsp_valid[i]), 32'd0);
         check_eq("rst_err",   32'(rsp_err[i]),   32'd0);
         check_eq("rst_rdata", rsp_rdata[i],      32'd0);
      end
      rst_ni = 1'b1;
      cycle();

      // Write then read back, RD_LAT=2.
      txn(0, 1'b1, 10'd5, 32'hDEADBEEF, 32'd0,        1'b0, "t2_w");
      txn(0, 1'b0, 10'd5, 32'd0,        32'hDEADBEEF, 1'b0, "t2_r");

      // Back-pressure: response held while rsp_ready is low.
      rsp_ready[0] = 1'b0;
      accept(0, 1'b0, 10'd5, 32'd0, "t3");
      wait_rsp(0, "t3");
      check_eq("t3_rdata0", rsp_rdata[0], 32'hDEADBEEF);
      for (int k = 0; k < 4; k++) begin
         cycle();
         check_eq("t3_hold_vld",   32'(rsp_valid[0]), 32'd1);
         check_eq("t3_hold_rdata", rsp_rdata[0],      32'hDEADBEEF);
         check_eq("t3_hold_rdy",   32'(req_ready[0]), 32'd0);
      end
      rsp_ready[0] = 1'b1;
      cycle();
      check_eq("t3_vld0", 32'(rsp_valid[0]), 32'd0);
      check_eq("t3_rdy1", 32'(req_ready[0]), 32'd1);

      // Out of range on DEPTH=1000; word 0 must not be aliased.
      txn(0, 1'b1, 10'd0,    32'hA5A50000, 32'd0,        1'b0, "t4_w0");
      txn(0, 1'b1, 10'd999,  32'h00000099, 32'd0,        1'b0, "t4_w999");
      txn(0, 1'b0, 10'd999,  32'd0,        32'h00000099, 1'b0, "t4_r999");
      txn(0, 1'b1, 10'd1000, 32'd1,        32'd0,        1'b1, "t4_w1000");
      txn(0, 1'b0, 10'd1000, 32'd0,        32'd0,        1'b1, "t4_r1000");
      txn(0, 1'b0, 10'd1023, 32'd0,        32'd0,        1'b1, "t4_r1023");
      txn(0, 1'b0, 10'd0,    32'd0,        32'hA5A50000, 1'b0, "t4_r0");

      // A request presented during WAIT is ignored.
      txn(0, 1'b1, 10'd9,  32'h0BADF00D, 32'd0, 1'b0, "t6_w9");
      txn(0, 1'b1, 10'd10, 32'h11112222, 32'd0, 1'b0, "t6_w10");
      rsp_ready[0] = 1'b1;
      accept(0, 1'b0, 10'd9, 32'd0, "t6");
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b1;
      req_addr[0]  = 10'd10;
      req_wdata[0] = 32'hFFFFFFFF;
      check_eq("t6_rdy_wait", 32'(req_ready[0]), 32'd0);
      cycle();
      req_valid[0] = 1'b0;
      req_we[0]    = 1'b0;
      check_eq("t6_vld_early", 32'(rsp_valid[0]), 32'd0);
      cycle();
      check_eq("t6_vld",   32'(rsp_valid[0]), 32'd1);
      check_eq("t6_rdata", rsp_rdata[0],      32'h0BADF00D);
      check_eq("t6_err",   32'(rsp_err[0]),   32'd0);
      cycle();
      check_eq("t6_vld0", 32'(rsp_valid[0]), 32'd0);
      txn(0, 1'b0, 10'd10, 32'd0, 32'h11112222, 1'b0, "t6_r10");

      // Asynchronous reset while a response is pending.
      txn(0, 1'b1, 10'd7, 32'h12345678, 32'd0, 1'b0, "t1_w");
      rsp_ready[0] = 1'b0;
      accept(0, 1'b0, 10'd7, 32'd0, "t1_r");
      wait_rsp(0, "t1_r");
      check_eq("t1_pre_vld", 32'(rsp_valid[0]), 32'd1);
      rst_ni = 1'b0;
      #1;
      check_eq("t1_vld",   32'(rsp_valid[0]), 32'd0);
      check_eq("t1_err",   32'(rsp_err[0]),   32'd0);
      check_eq("t1_rdy",   32'(req_ready[0]), 32'd1);
      check_eq("t1_rdata", rsp_rdata[0],      32'd0);
      #3;
      rst_ni = 1'b1;
      cycle();
      txn(0, 1'b0, 10'd7, 32'd0, 32'h12345678, 1'b0, "t1_rb");

      // Latency sweep and back-to-back throughput.
      txn(1, 1'b1, 10'd3, 32'hCAFE0001, 32'd0,        1'b0, "t5a_w");
      txn(1, 1'b0, 10'd3, 32'd0,        32'hCAFE0001, 1'b0, "t5a_r");
      txn(2, 1'b1, 10'd3, 32'hCAFE0008, 32'd0,        1'b0, "t5b_w");
      txn(2, 1'b0, 10'd3, 32'd0,        32'hCAFE0008, 1'b0, "t5b_r");
      stream(1, "t5a_s");
      stream(2, "t5b_s");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
